// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: burst size codes, rw encoding,
// sequencer states and the size-to-beat-count mapping.
package mem_pkg;

  localparam logic [1:0] SZ_1W  = 2'b00;
  localparam logic [1:0] SZ_4W  = 2'b01;
  localparam logic [1:0] SZ_8W  = 2'b10;
  localparam logic [1:0] SZ_16W = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Requester index: bit 0 is fetch, bit 1 is load/store.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam logic [31:0] MEM_START_ADDR = 32'h8002_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [4:0] size_beats(input logic [1:0] sz);
    case (sz)
      SZ_1W:   return 5'd1;
      SZ_4W:   return 5'd4;
      SZ_8W:   return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on contention the
// requester that did not own the previous burst wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-word memory port between fetch and load/store, splitting
// each 1/4/8/16-word burst into consecutive single-word accesses.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [1:0]        if_size,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_rw,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [1:0]        ls_size,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_wready,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [1:0]        mem_access_size,
  output logic              mem_rw,
  output logic              mem_enable,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t            state, state_nx;
  logic [1:0]        grant;
  logic [3:0]        beat;
  logic [4:0]        beats;
  logic [ADDR_W-1:0] base;
  logic              owner, last_owner, rw_q, rd_pend, last_beat;

  rr_arb2 u_arb (
    .req   ({ls_req, if_req}),
    .last  (last_owner),
    .grant (grant)
  );

  assign last_beat = ({1'b0, beat} == beats - 5'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      beat       <= '0;
      beats      <= '0;
      base       <= '0;
      owner      <= OWN_IF;
      rw_q       <= 1'b0;
      last_owner <= OWN_LS;
      rd_pend    <= 1'b0;
    end else begin
      state   <= state_nx;
      // Memory output is registered, so a read issued now returns next cycle.
      rd_pend <= (state == ST_ISSUE) && (rw_q == RW_READ);
      case (state)
        ST_IDLE: if (|grant) begin
          owner <= grant[1];
          rw_q  <= grant[1] ? ls_rw : RW_READ;
          base  <= (grant[1] ? ls_addr : if_addr) & ~ADDR_W'(3);
          beats <= size_beats(grant[1] ? ls_size : if_size);
          beat  <= '0;
        end
        ST_ISSUE: beat       <= beat + 4'd1;
        ST_DRAIN: last_owner <= owner;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    mem_enable  = 1'b0;
    mem_rw      = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    ls_wready   = 1'b0;
    if_done     = 1'b0;
    ls_done     = 1'b0;
    case (state)
      ST_IDLE: if (|grant) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        mem_enable  = 1'b1;
        mem_rw      = rw_q;
        mem_address = base + ADDR_W'(WORD_BYTES * int'(beat));
        if (rw_q == RW_WRITE) begin
          mem_data_in = ls_wdata;
          ls_wready   = 1'b1;
        end
        if (last_beat) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if_done  = (owner == OWN_IF);
        ls_done  = (owner == OWN_LS);
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign mem_access_size = SZ_1W;
  assign if_rvalid       = rd_pend && (owner == OWN_IF);
  assign ls_rvalid       = rd_pend && (owner == OWN_LS);
  assign if_rdata        = if_rvalid ? mem_data_out : '0;
  assign ls_rdata        = ls_rvalid ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: burst-schedule reference model checked every cycle,
// directed scenarios with literal expectations, then random two-sided traffic.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic        clock = 1'b0, reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [1:0]  if_size = '0;
  logic        if_rvalid, if_done;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0, ls_rw = 1'b0;
  logic [31:0] ls_addr = '0, ls_wdata = '0;
  logic [1:0]  ls_size = '0;
  logic        ls_wready, ls_rvalid, ls_done;
  logic [31:0] ls_rdata;
  logic [31:0] mem_address, mem_data_in;
  logic [31:0] mem_data_out = '0;
  logic [1:0]  mem_access_size;
  logic        mem_rw, mem_enable;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_size(if_size),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_done(if_done),
    .ls_req(ls_req), .ls_rw(ls_rw), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_wready(ls_wready), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ls_done(ls_done),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_access_size(mem_access_size), .mem_rw(mem_rw),
    .mem_enable(mem_enable), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int beats_tab[4] = '{1, 4, 8, 16};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got no done pulse within the cycle budget, required one", nm);
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // Stand-in data_memory: registered read data, write on the enabled edge.
  logic [31:0] dev_mem [logic [31:0]];
  initial forever begin
    @(posedge clock);
    if (mem_enable) begin
      if (mem_rw) mem_data_out <= dev_mem.exists(mem_address) ? dev_mem[mem_address] : dflt(mem_address);
      else dev_mem[mem_address] = mem_data_in;
    end
  end

  // Reference model: a granted burst at edge g owns cycles g..g+n-1 (issue),
  // g+n (done), and the next grant can happen no earlier than edge g+n+2.
  logic [31:0] ref_mem [logic [31:0]];
  bit          m_act = 0, m_own = 0, m_rw = 0, m_last = 1;
  int          m_g = 0, m_n = 0, m_free = 0;
  logic [31:0] m_base = '0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
    if (reset) begin
      m_act  = 0;
      m_last = 1;
      m_free = cyc + 1;
    end else begin
      if (m_act && !m_rw && cyc - 1 >= m_g && cyc - 1 < m_g + m_n)
        ref_mem[m_base + 32'(cyc - 1 - m_g) * 32'd4] = ls_wdata;
      if (m_act && cyc >= m_g + m_n + 1) begin
        m_act  = 0;
        m_last = m_own;
      end
      if (!m_act && cyc >= m_free && (if_req || ls_req)) begin
        m_own  = (if_req && ls_req) ? !m_last : ls_req;
        m_rw   = m_own ? ls_rw : 1'b1;
        m_base = (m_own ? ls_addr : if_addr) & 32'hFFFF_FFFC;
        m_n    = beats_tab[m_own ? ls_size : if_size];
        m_g    = cyc;
        m_act  = 1;
        m_free = cyc + m_n + 2;
      end
    end
  end

  logic        e_en, e_dn, e_rv;
  logic [31:0] e_a, e_rd;
  int          ls_done_cnt = 0;
  logic [31:0] addr_log[$];
  int          done_log[$];

  initial forever begin
    @(negedge clock);
    e_en = !reset && m_act && cyc >= m_g && cyc < m_g + m_n;
    e_dn = !reset && m_act && cyc == m_g + m_n;
    e_rv = !reset && m_act && m_rw && cyc > m_g && cyc <= m_g + m_n;
    e_a  = e_en ? m_base + 32'(cyc - m_g) * 32'd4 : 32'd0;
    e_rd = e_rv ? ref_rd(m_base + 32'(cyc - m_g - 1) * 32'd4) : 32'd0;
    chk("mem_enable", 32'(mem_enable), 32'(e_en));
    chk("mem_address", mem_address, e_a);
    chk("mem_rw", 32'(mem_rw), 32'(e_en && m_rw));
    chk("mem_data_in", mem_data_in, (e_en && !m_rw) ? ls_wdata : 32'd0);
    chk("mem_access_size", 32'(mem_access_size), 32'd0);
    chk("ls_wready", 32'(ls_wready), 32'(e_en && !m_rw));
    chk("if_done", 32'(if_done), 32'(e_dn && !m_own));
    chk("ls_done", 32'(ls_done), 32'(e_dn && m_own));
    chk("if_rvalid", 32'(if_rvalid), 32'(e_rv && !m_own));
    chk("if_rdata", if_rdata, m_own ? 32'd0 : e_rd);
    chk("ls_rvalid", 32'(ls_rvalid), 32'(e_rv && m_own));
    chk("ls_rdata", ls_rdata, m_own ? e_rd : 32'd0);
    if (mem_enable) addr_log.push_back(mem_address);
    if (if_done) done_log.push_back(0);
    if (ls_done) begin
      done_log.push_back(1);
      ls_done_cnt++;
    end
  end

  // Requester drivers: called just after a rising edge, return just after
  // the rising edge that ends the done cycle.
  task automatic ls_burst(input logic rw, input logic [31:0] addr, input logic [1:0] sz,
                          input logic [31:0] w0, input int mangle,
                          output int wr, output int rv, output int dn, output int rvc,
                          output logic [31:0] rd);
    bit w, mangled;
    mangled = 0;
    ls_req = 1'b1; ls_rw = rw; ls_addr = addr; ls_size = sz; ls_wdata = w0;
    wr = 0; rv = 0; dn = -1; rvc = -1; rd = '0;
    for (int i = 0; i < 80 && dn < 0; i++) begin
      @(negedge clock);
      w = ls_wready;
      if (w) wr++;
      if (ls_rvalid) begin rv++; rvc = cyc; rd = ls_rdata; end
      if (ls_done) dn = cyc;
      @(posedge clock);
      #1;
      if (w) ls_wdata = $urandom;
      if (mangle > 0 && wr == mangle && !mangled) begin
        mangled = 1;
        ls_addr = ls_addr + 32'h40; ls_size = SZ_1W; ls_rw = RW_READ; ls_req = 1'b0;
      end
    end
    if (dn < 0) tmo("ls_burst_timeout");
    ls_req = 1'b0;
  endtask

  task automatic if_burst(input logic [31:0] addr, input logic [1:0] sz,
                          output int rv, output int dn, output int rvc, output logic [31:0] rd);
    if_req = 1'b1; if_addr = addr; if_size = sz;
    rv = 0; dn = -1; rvc = -1; rd = '0;
    for (int i = 0; i < 80 && dn < 0; i++) begin
      @(negedge clock);
      if (if_rvalid) begin rv++; rvc = cyc; rd = if_rdata; end
      if (if_done) dn = cyc;
      @(posedge clock);
      #1;
    end
    if (dn < 0) tmo("if_burst_timeout");
    if_req = 1'b0;
  endtask

  task automatic rand_if(input int nb);
    int rv, dn, rvc, gap;
    logic [31:0] rd;
    logic [1:0] sz;
    for (int k = 0; k < nb; k++) begin
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin repeat (gap) @(posedge clock); #1; end
      sz = 2'($urandom_range(0, 3));
      if_burst(MEM_START_ADDR + 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3)),
               sz, rv, dn, rvc, rd);
      chk("rand_if_rvalid_count", 32'(rv), 32'(beats_tab[sz]));
    end
  endtask

  task automatic rand_ls(input int nb);
    int wr, rv, dn, rvc, gap;
    logic [31:0] rd;
    logic [1:0] sz;
    logic rw;
    for (int k = 0; k < nb; k++) begin
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin repeat (gap) @(posedge clock); #1; end
      sz = 2'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      ls_burst(rw, MEM_START_ADDR + 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3)),
               sz, $urandom, 0, wr, rv, dn, rvc, rd);
      chk("rand_ls_wready_count", 32'(wr), rw ? 32'd0 : 32'(beats_tab[sz]));
      chk("rand_ls_rvalid_count", 32'(rv), rw ? 32'(beats_tab[sz]) : 32'd0);
    end
  endtask

  initial begin
    int wr, rv, dn, rvc, t0, c0, c1;
    logic [31:0] rd;
    int exp_ord[4] = '{0, 1, 0, 1};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_mem_enable", 32'(mem_enable), 32'd0);
    chk("rst_ls_done", 32'(ls_done), 32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Single-word write then read back.
    t0 = cyc;
    ls_burst(RW_WRITE, MEM_START_ADDR, SZ_1W, 32'hDEADBEEF, 0, wr, rv, dn, rvc, rd);
    chk("wr1_wready_count", 32'(wr), 32'd1);
    chk("wr1_done_cycle", 32'(dn), 32'(t0 + 2));
    t0 = cyc;
    ls_burst(RW_READ, MEM_START_ADDR, SZ_1W, 32'd0, 0, wr, rv, dn, rvc, rd);
    chk("rd1_rdata", rd, 32'hDEADBEEF);
    chk("rd1_rvalid_count", 32'(rv), 32'd1);
    chk("rd1_rvalid_with_done", 32'(rvc), 32'(dn));
    chk("rd1_done_cycle", 32'(dn), 32'(t0 + 2));

    // 16-word fetch burst.
    addr_log.delete();
    t0 = cyc;
    if_burst(32'h8002_0040, SZ_16W, rv, dn, rvc, rd);
    chk("f16_rvalid_count", 32'(rv), 32'd16);
    chk("f16_done_on_last_rvalid", 32'(rvc), 32'(dn));
    chk("f16_done_cycle", 32'(dn), 32'(t0 + 17));
    chk("f16_addr_count", 32'(addr_log.size()), 32'd16);
    if (addr_log.size() == 16)
      for (int i = 0; i < 16; i++)
        chk($sformatf("f16_addr%0d", i), addr_log[i], 32'h8002_0040 + 32'(i) * 32'd4);

    // Contention straight out of reset, both requesters held for two bursts.
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    done_log.delete();
    fork
      begin
        int a_rv, a_dn, a_rvc; logic [31:0] a_rd;
        if_burst(MEM_START_ADDR + 32'h80, SZ_1W, a_rv, a_dn, a_rvc, a_rd);
        if_burst(MEM_START_ADDR + 32'h84, SZ_4W, a_rv, a_dn, a_rvc, a_rd);
      end
      begin
        int b_wr, b_rv, b_dn, b_rvc; logic [31:0] b_rd;
        ls_burst(RW_WRITE, MEM_START_ADDR + 32'h90, SZ_1W, 32'h1234_5678, 0, b_wr, b_rv, b_dn, b_rvc, b_rd);
        ls_burst(RW_READ, MEM_START_ADDR + 32'h90, SZ_1W, 32'd0, 0, b_wr, b_rv, b_dn, b_rvc, b_rd);
        chk("cont_ls_readback", b_rd, 32'h1234_5678);
      end
    join
    chk("cont_done_count", 32'(done_log.size()), 32'd4);
    if (done_log.size() == 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("cont_order%0d", i), 32'(done_log[i]), 32'(exp_ord[i]));

    // 8-word write with addr/size/rw changed and req dropped at beat 3.
    addr_log.delete();
    c0 = ls_done_cnt;
    ls_burst(RW_WRITE, MEM_START_ADDR + 32'h100, SZ_8W, 32'h1111_0000, 3, wr, rv, dn, rvc, rd);
    repeat (4) @(posedge clock);
    #1;
    chk("mid_wready_count", 32'(wr), 32'd8);
    chk("mid_done_count", 32'(ls_done_cnt - c0), 32'd1);
    chk("mid_addr_count", 32'(addr_log.size()), 32'd8);
    if (addr_log.size() == 8)
      for (int i = 0; i < 8; i++)
        chk($sformatf("mid_addr%0d", i), addr_log[i], MEM_START_ADDR + 32'h100 + 32'(i) * 32'd4);

    // Reset during beat 2 of a 4-word read.
    c0 = ls_done_cnt;
    ls_req = 1'b1; ls_rw = RW_READ; ls_addr = MEM_START_ADDR + 32'h200; ls_size = SZ_4W;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_mid_beat2_addr", mem_address, MEM_START_ADDR + 32'h208);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_enable", 32'(mem_enable), 32'd0);
    chk("rst_mid_address", mem_address, 32'd0);
    chk("rst_mid_rvalid", 32'(ls_rvalid), 32'd0);
    chk("rst_mid_done", 32'(ls_done), 32'd0);
    ls_req = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_mid_no_done", 32'(ls_done_cnt - c0), 32'd0);
    ls_burst(RW_READ, MEM_START_ADDR, SZ_1W, 32'd0, 0, wr, rv, dn, rvc, rd);
    chk("rst_after_rdata", rd, 32'hDEADBEEF);
    chk("rst_after_done_count", 32'(ls_done_cnt - c0), 32'd1);

    // Misaligned base wrapping past the top of the address space.
    addr_log.delete();
    ls_burst(RW_READ, 32'hFFFF_FFFE, SZ_4W, 32'd0, 0, wr, rv, dn, rvc, rd);
    chk("wrap_addr_count", 32'(addr_log.size()), 32'd4);
    if (addr_log.size() == 4) begin
      chk("wrap_addr0", addr_log[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", addr_log[1], 32'h0000_0000);
      chk("wrap_addr2", addr_log[2], 32'h0000_0004);
      chk("wrap_addr3", addr_log[3], 32'h0000_0008);
    end

    // Random concurrent traffic against the model.
    fork
      rand_if(30);
      rand_ls(30);
    join
    c1 = ls_done_cnt;
    repeat (5) @(posedge clock);
    #1;
    chk("final_idle_enable", 32'(mem_enable), 32'd0);
    chk("final_no_extra_done", 32'(ls_done_cnt - c1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and burst sequencer in front of data_memory.
- Shares the single memory port between instruction fetch (if_) and load/store (ls_).
- Breaks every 1/4/8/16-word burst into single-word memory accesses (access_size 00) at consecutive addresses.
- Returns read beats with a valid strobe, paces write beats with a ready strobe and signals burst completion.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data/word width.
- WORD_BYTES, 4, address increment per beat.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous active-high reset.
- if_req  in  1  fetch burst request, held until if_done.
- if_addr  in  ADDR_W  fetch burst base byte address.
- if_size  in  2  burst length code: 00=1, 01=4, 10=8, 11=16 words.
- if_rvalid  out  1  fetch read beat valid.
- if_rdata  out  DATA_W  fetch read beat data.
- if_done  out  1  one-cycle pulse when the fetch burst completes.
- ls_req  in  1  load/store burst request, held until ls_done.
- ls_rw  in  1  1=read, 0=write.
- ls_addr  in  ADDR_W  load/store burst base byte address.
- ls_size  in  2  burst length code, same encoding as if_size.
- ls_wdata  in  DATA_W  write data for the current beat.
- ls_wready  out  1  write beat consumed this cycle; requester advances ls_wdata.
- ls_rvalid  out  1  load/store read beat valid.
- ls_rdata  out  DATA_W  load/store read beat data.
- ls_done  out  1  one-cycle pulse when the load/store burst completes.
- mem_address  out  ADDR_W  to data_memory address.
- mem_data_in  out  DATA_W  to data_memory data_in.
- mem_access_size  out  2  tied to 00 (single word).
- mem_rw  out  1  to data_memory rw (1=read).
- mem_enable  out  1  to data_memory enable.
- mem_data_out  in  DATA_W  from data_memory data_out; registered, valid one cycle after the issuing edge.

Behaviour:
- Reset (async, active-high) values:
  - State IDLE; beat counter, base and owner registers cleared; last_owner=ls, so the first contention goes to fetch.
  - Every output is 0.
  - Asserting reset mid-burst abandons the burst: no done pulse is produced, and memory words already written remain written.
- States:
  - IDLE: no requests pending, remain in IDLE. With any request, grant and move to ISSUE.
    - Grant: a single pending requester wins. With both pending, round-robin: the requester that is not last_owner wins.
    - On grant, latch owner, rw (fetch is always read), base = addr with bits [1:0] forced to 0, and beats = 1/4/8/16 from size.
  - ISSUE, one beat per cycle:
    - mem_enable=1, mem_rw=latched rw, mem_address=base+WORD_BYTES*beat (modulo 2^ADDR_W wrap, no error).
    - For a write: mem_data_in=ls_wdata and ls_wready=1 in the same cycle.
    - beat increments each cycle. After the beat with index beats-1, move to DRAIN.
  - DRAIN, one cycle:
    - mem_enable=0.
    - Owner's done=1. For a read, the last rvalid also falls in this cycle.
    - last_owner updates to owner. Next state IDLE.
- Read return:
  - owner_rvalid is asserted the cycle after each read beat is issued; owner_rdata=mem_data_out.
  - The non-owner's rvalid and rdata stay 0.
- Latency:
  - req seen high at edge N gives the first mem_enable in cycle N+1.
  - An n-word burst occupies n+2 cycles, IDLE included. Back-to-back bursts are separated by that IDLE cycle.
- Request inputs are sampled only in IDLE.
  - addr, size and rw changes or req deassertion during a burst are ignored; the burst always completes.
  - Requester may drop req in the cycle after done; if req is still high at the IDLE cycle, a new burst starts.
- Simultaneous requests in IDLE: round-robin as above; the loser waits, and no request is ever dropped.
- ls_wready and the rvalids are never asserted outside ISSUE/DRAIN. mem_access_size is always 00.

Decomposition:
- Shared package mem_pkg: size codes (SZ_1W=00, SZ_4W=01, SZ_8W=10, SZ_16W=11), a size-to-beats function, RW_READ=1 / RW_WRITE=0, state encodings, and MEM_START_ADDR=32'h80020000 for benches.
- The round-robin grant logic is a natural sub-module, rr_arb2 (req[1:0], last, grant[1:0]). Sequencer and datapath stay in mem_arbiter.

Test Plan:
- Single-word write then read, ls side: ls write 0x80020000 size 00 data 0xDEADBEEF; then read the same address. Required:
  - Write: one ls_wready pulse, ls_done 2 cycles after grant.
  - Read: ls_rvalid with 0xDEADBEEF together with ls_done.
- 16-word fetch burst: if_addr=0x80020040 size 11. Required:
  - mem_address steps 0x80020040..0x8002007C in 16 consecutive cycles.
  - 16 if_rvalid pulses in order; if_done on the 16th.
- Contention: if_req and ls_req both rise the same cycle from reset. Required:
  - Fetch is served first, then ls.
  - Repeated simultaneous requests then alternate ls, if, ls.
- Mid-burst input change: ls 8-word write; ls_addr and ls_size are changed, and ls_req is dropped, at beat 3. Required:
  - All 8 beats complete at the original addresses.
  - Exactly 8 ls_wready pulses and one ls_done.
- Reset mid-burst: assert reset during beat 2 of a 4-word read. Required:
  - Outputs go 0 immediately (asynchronously); no done pulse.
  - After release, a new 1-word read completes normally.
- Misaligned and wrap: ls read addr 0xFFFFFFFE size 01. Required: addresses issued are 0xFFFFFFFC, 0x00000000, 0x00000004, 0x00000008.
